// File: rtl/ll_pkg.sv
// Shared definitions for the linked-list multi-queue.
//   ptr_w(depth)  : node pointer width for a pool of 'depth' nodes
//   cnt_w(depth)  : width able to hold 0..depth (list counts, free count)
//   lw(num_lists) : list-select width, at least one bit
//   node_idx_t    : node index for the default 16-node pool
package ll_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic int lw(input int num_lists);
    return (num_lists > 1) ? $clog2(num_lists) : 1;
  endfunction

  localparam int DEFAULT_DEPTH = 16;
  typedef logic [ptr_w(DEFAULT_DEPTH)-1:0] node_idx_t;

endpackage

// File: rtl/ll_node_ram.sv
// Payload storage for the node pool: DEPTH x DATA_W.
//   we/waddr/wdata : single write port
//   re/raddr       : read request; rd_data is registered and holds between reads
// The array itself is not reset; only the read register is.
module ll_node_ram
  import ll_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [PW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PW-1:0]     raddr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (re) rd_data <= mem[raddr];
  end

endmodule

// File: rtl/ll_multi_queue.sv
// NUM_LISTS independent FIFO linked lists sharing one pool of DEPTH nodes.
// Ports:
//   push_valid/push_list/push_data, push_ready : append to a list
//   pop_valid/pop_list, pop_ready              : remove a list head
//   rd_valid/rd_data/rd_list                   : popped payload, one cycle later
//   empty[i], free_count, full                 : registered status
// Handshake: a transfer happens on a rising edge where valid && ready. ready
// depends only on registered state (never on the partner valid or on the
// other port), so it may be sampled before valid is raised.
module ll_multi_queue
  import ll_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int NUM_LISTS = 4,
  localparam int PW       = ptr_w(DEPTH),
  localparam int CW       = cnt_w(DEPTH),
  localparam int LW       = lw(NUM_LISTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_valid,
  input  logic [LW-1:0]        push_list,
  input  logic [DATA_W-1:0]    push_data,
  output logic                 push_ready,
  input  logic                 pop_valid,
  input  logic [LW-1:0]        pop_list,
  output logic                 pop_ready,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  output logic [LW-1:0]        rd_list,
  output logic [NUM_LISTS-1:0] empty,
  output logic [CW-1:0]        free_count,
  output logic                 full
);

  typedef logic [PW-1:0] idx_t;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  idx_t            head_q [NUM_LISTS];
  idx_t            tail_q [NUM_LISTS];
  logic [CW-1:0]   cnt_q  [NUM_LISTS];
  idx_t            next_q [DEPTH];
  idx_t            free_head_q;

  logic            push_in_range, pop_in_range;
  logic [LW-1:0]   pu, po;
  logic            push_acc, pop_acc, same_list;
  idx_t            n, h;

  assign push_in_range = 32'(push_list) < NUM_LISTS;
  assign pop_in_range  = 32'(pop_list)  < NUM_LISTS;
  // Clamp indices so an out-of-range select never reads past the arrays.
  assign pu = push_in_range ? push_list : '0;
  assign po = pop_in_range  ? pop_list  : '0;

  assign push_ready = (free_count != '0);
  assign pop_ready  = pop_in_range && (cnt_q[po] != '0);
  assign full       = (free_count == '0);

  assign push_acc  = push_valid && push_ready && push_in_range;
  assign pop_acc   = pop_valid && pop_ready;
  assign same_list = push_acc && pop_acc && (pu == po);
  assign n         = free_head_q;
  assign h         = head_q[po];

  always_comb begin
    empty = '0;
    for (int i = 0; i < NUM_LISTS; i++) empty[i] = (cnt_q[i] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LISTS; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      for (int i = 0; i < DEPTH; i++) next_q[i] <= PW'(i + 1);
      free_head_q <= '0;
      free_count  <= CW'(DEPTH);
      rd_valid    <= 1'b0;
      rd_list     <= '0;
    end else begin
      rd_valid <= pop_acc;

      // Free list. With both ports active the popped node replaces the
      // allocated one at the top of the free stack, so free_count holds.
      if (push_acc && pop_acc) begin
        next_q[h]   <= next_q[n];
        free_head_q <= h;
      end else if (push_acc) begin
        free_head_q <= next_q[n];
        free_count  <= free_count - CNT_ONE;
      end else if (pop_acc) begin
        next_q[h]   <= free_head_q;
        free_head_q <= h;
        free_count  <= free_count + CNT_ONE;
      end

      if (pop_acc) begin
        head_q[po] <= next_q[h];
        rd_list    <= po;
        if (!same_list) cnt_q[po] <= cnt_q[po] - CNT_ONE;
      end

      if (push_acc) begin
        // A list that is empty, or whose only node leaves this cycle, gets
        // n as its sole node; next[h] is left to the free-list update.
        if (cnt_q[pu] == '0 || (same_list && cnt_q[pu] == CNT_ONE)) begin
          head_q[pu] <= n;
        end else begin
          next_q[tail_q[pu]] <= n;
        end
        tail_q[pu] <= n;
        if (!same_list) cnt_q[pu] <= cnt_q[pu] + CNT_ONE;
      end
    end
  end

  ll_node_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (push_acc),
    .waddr   (n),
    .wdata   (push_data),
    .re      (pop_acc),
    .raddr   (h),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_ll_multi_queue.sv
module tb_ll_multi_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int NL     = 4;
  localparam int LW     = 2;
  localparam int W      = LW + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              push_valid;
  logic [LW-1:0]     push_list;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop_valid;
  logic [LW-1:0]     pop_list;
  logic              pop_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [LW-1:0]     rd_list;
  logic [NL-1:0]     empty;
  logic [4:0]        free_count;
  logic              full;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ll_multi_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_LISTS(NL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_list  (push_list),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_list   (pop_list),
    .pop_ready  (pop_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_list    (rd_list),
    .empty      (empty),
    .free_count (free_count),
    .full       (full)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] mq[NL][$];
  int                model_free;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NL-1:0] model_empty();
    logic [NL-1:0] e;
    for (int i = 0; i < NL; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) mq[i].delete();
    exp_q.delete();
    model_free = DEPTH;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".free_count"}, 32'(free_count), 32'(model_free));
    check({tag, ".empty"}, 32'(empty), 32'(model_empty()));
    check({tag, ".full"}, 32'(full), 32'(model_free == 0));
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus: expected acceptance comes from the model, the
  // popped value is queued, then compared against rd_* after the edge.
  task automatic step(input bit pv, input int pl, input logic [DATA_W-1:0] pd,
                      input bit ov, input int ol);
    bit exp_push, exp_pop;
    logic [W-1:0] e;
    @(negedge clk);
    push_valid = pv; push_list = LW'(pl); push_data = pd;
    pop_valid  = ov; pop_list  = LW'(ol);
    #1;
    check("push_ready", 32'(push_ready), 32'(model_free > 0));
    check("pop_ready", 32'(pop_ready), 32'(mq[ol].size() != 0));
    exp_push = pv && (model_free > 0);
    exp_pop  = ov && (mq[ol].size() != 0);
    if (exp_pop) begin
      exp_q.push_back({LW'(ol), mq[ol].pop_front()});
      model_free++;
    end
    if (exp_push) begin
      mq[pl].push_back(pd);
      model_free--;
    end
    @(posedge clk);
    #1;
    push_valid = 1'b0; pop_valid = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'(exp_pop));
    if (exp_pop && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rd_data", 32'(rd_data), 32'(e[DATA_W-1:0]));
      check("rd_list", 32'(rd_list), 32'(e[W-1:DATA_W]));
    end
    check_status("post");
  endtask

  task automatic drain_all();
    for (int k = 0; k < 4 * DEPTH; k++) begin
      for (int l = 0; l < NL; l++) if (mq[l].size() != 0) step(0, 0, 8'h00, 1, l);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    push_valid = 1'b0; push_list = '0; push_data = '0;
    pop_valid = 1'b0; pop_list = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst.rd_valid", 32'(rd_valid), 32'd0);
    check("rst.rd_data", 32'(rd_data), 32'd0);
    check("rst.rd_list", 32'(rd_list), 32'd0);
    check_status("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic FIFO on list 2
    step(1, 2, 8'h11, 0, 0);
    step(1, 2, 8'h22, 0, 0);
    step(1, 2, 8'h33, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 2);
    check("basic.empty2", 32'(empty[2]), 32'd1);
    check("basic.free", 32'(free_count), 32'd16);

    // Fill the pool round-robin, overflow push refused
    for (int i = 0; i < DEPTH; i++) step(1, i % NL, 8'($urandom_range(0, 255)), 0, 0);
    check("fill.full", 32'(full), 32'd1);
    step(1, 0, 8'hEE, 0, 0);
    // Full pool: push refused even with a concurrent pop
    step(1, 1, 8'hDD, 1, 0);
    check("fullpop.free", 32'(free_count), 32'd1);
    drain_all();
    check("drain.free", 32'(free_count), 32'd16);

    // Single-node list: simultaneous pop and push on the same list
    step(1, 3, 8'hA5, 0, 0);
    step(1, 3, 8'h5A, 1, 3);
    step(0, 0, 8'h00, 1, 3);
    check("swap.empty3", 32'(empty[3]), 32'd1);

    // Pop of empty list is not bypassed by a same-cycle push
    step(1, 0, 8'h77, 1, 0);
    check("nobypass.empty0", 32'(empty[0]), 32'd0);
    drain_all();

    // Random mixed traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom_range(0, NL - 1), 8'($urandom_range(0, 255)),
           $urandom_range(0, 1), $urandom_range(0, NL - 1));
    drain_all();

    // Reset with 5 nodes queued and a pop result in flight
    for (int i = 0; i < 5; i++) step(1, i % NL, 8'(8'h40 + i), 0, 0);
    @(negedge clk);
    pop_valid = 1'b1; pop_list = 2'd0;
    @(posedge clk);
    #1;
    pop_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("arst.rd_valid", 32'(rd_valid), 32'd0);
    check("arst.empty", 32'(empty), 32'hF);
    check("arst.free", 32'(free_count), 32'd16);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 8'h9C, 0, 0);
    step(1, 1, 8'h9D, 1, 1);
    step(0, 0, 8'h00, 1, 1);

    check("sb.leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog: the run is bounded well below this.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
